// File: rtl/ebr_pingpong_scheduler.sv
// ebr_pingpong_scheduler
// Ping-pong scheduler for two EBR banks. Bytes from an i2c filler are written
// into the current write bank; a bank is handed to the consumer when a frame
// ends (wr_last) or the bank fills. The consumer releases banks in completion
// order with rd_done. Bytes arriving while the write bank is still owned by
// the consumer are dropped and flagged via a sticky overflow bit.
module ebr_pingpong_scheduler #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic [1:0]        ebr_we,
    output logic [ADDR_W-1:0] ebr_waddr,
    output logic [7:0]        ebr_wdata,
    output logic              rd_bank_valid,
    output logic              rd_bank,
    output logic [ADDR_W:0]   rd_len,
    input  logic              rd_done,
    output logic              overflow
);

    // Index of the last byte slot in a bank, and a width-matched increment.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    // Bank ownership and fill state.
    logic [1:0]        full_q,    full_d;
    logic [ADDR_W:0]   len_q [2];
    logic [ADDR_W:0]   len_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W:0]   wr_cnt_q,  wr_cnt_d;
    logic              rd_bank_q, rd_bank_d;

    // Registered EBR write port.
    logic [1:0]        ebr_we_q,    ebr_we_d;
    logic [ADDR_W-1:0] ebr_waddr_q, ebr_waddr_d;
    logic [7:0]        ebr_wdata_q, ebr_wdata_d;

    logic              overflow_q,  overflow_d;

    logic              accept;
    logic              complete;
    logic              release_bank;

    // Handshake decode; wr_ready comes straight from the flag register, so a
    // bank released this cycle only becomes writable from the next cycle on.
    always_comb begin
        wr_ready     = ~full_q[wr_bank_q];
        accept       = wr_valid & wr_ready;
        complete     = accept & (wr_last | (wr_cnt_q == LAST_IDX));
        release_bank = rd_done & full_q[rd_bank_q];
    end

    // Next-state: write path, bank completion, consumer release, overflow.
    always_comb begin
        full_d      = full_q;
        len_d[0]    = len_q[0];
        len_d[1]    = len_q[1];
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_bank_d   = rd_bank_q;
        ebr_we_d    = 2'b00;
        ebr_waddr_d = ebr_waddr_q;
        ebr_wdata_d = ebr_wdata_q;
        overflow_d  = overflow_q;

        if (accept) begin
            ebr_we_d[wr_bank_q] = 1'b1;
            ebr_waddr_d         = wr_cnt_q[ADDR_W-1:0];
            ebr_wdata_d         = wr_data;
            if (complete) begin
                full_d[wr_bank_q] = 1'b1;
                len_d[wr_bank_q]  = wr_cnt_q + CNT_ONE;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_ONE;
            end
        end

        // A dropped byte (including its wr_last) only raises overflow.
        if (wr_valid && !wr_ready) begin
            overflow_d = 1'b1;
        end

        // Completion and release can never target the same bank (one needs
        // the flag clear, the other set), so both apply independently.
        if (release_bank) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    // State registers with synchronous reset that discards all bank contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q      <= 2'b00;
            len_q[0]    <= '0;
            len_q[1]    <= '0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            ebr_we_q    <= 2'b00;
            ebr_waddr_q <= '0;
            ebr_wdata_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            len_q[0]    <= len_d[0];
            len_q[1]    <= len_d[1];
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_bank_q   <= rd_bank_d;
            ebr_we_q    <= ebr_we_d;
            ebr_waddr_q <= ebr_waddr_d;
            ebr_wdata_q <= ebr_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    // Output mapping; the read side is a pure register view.
    always_comb begin
        ebr_we        = ebr_we_q;
        ebr_waddr     = ebr_waddr_q;
        ebr_wdata     = ebr_wdata_q;
        rd_bank_valid = full_q[rd_bank_q];
        rd_bank       = rd_bank_q;
        rd_len        = len_q[rd_bank_q];
        overflow      = overflow_q;
    end

endmodule

// File: tb/tb_ebr_pingpong_scheduler.sv
// Directed testbench for ebr_pingpong_scheduler with DEPTH=4, ADDR_W=2.
module tb_ebr_pingpong_scheduler;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clock;
    logic              reset;
    logic              wr_valid;
    logic [7:0]        wr_data;
    logic              wr_last;
    logic              wr_ready;
    logic [1:0]        ebr_we;
    logic [ADDR_W-1:0] ebr_waddr;
    logic [7:0]        ebr_wdata;
    logic              rd_bank_valid;
    logic              rd_bank;
    logic [ADDR_W:0]   rd_len;
    logic              rd_done;
    logic              overflow;

    int n_checks = 0;
    int n_errors = 0;

    ebr_pingpong_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .ebr_we        (ebr_we),
        .ebr_waddr     (ebr_waddr),
        .ebr_wdata     (ebr_wdata),
        .rd_bank_valid (rd_bank_valid),
        .rd_bank       (rd_bank),
        .rd_len        (rd_len),
        .rd_done       (rd_done),
        .overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_done  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        wr_data = 8'h00;
        idle();
        #2;
        do_reset();

        // Reset state
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_bank_valid, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_rd_len", rd_len, 0);
        check("rst_ebr_we", ebr_we, 0);
        check("rst_overflow", overflow, 0);
        $display("reset: wr_ready=%0d rd_bank_valid=%0d", wr_ready, rd_bank_valid);

        // rd_done with nothing offered is ignored
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        check("ign_rd_bank", rd_bank, 0);
        check("ign_rd_valid", rd_bank_valid, 0);

        // Four bytes back-to-back fill bank 0
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'hA0 + 8'(i);
            wr_last  = 1'b0;
            tick();
            check("s1_we", ebr_we, 2'b01);
            check("s1_waddr", ebr_waddr, i);
            check("s1_wdata", ebr_wdata, 8'hA0 + i);
            $display("write A%0d: we=%b addr=%0d data=%h", i, ebr_we, ebr_waddr, ebr_wdata);
        end
        idle();
        check("s1_rd_valid", rd_bank_valid, 1);
        check("s1_rd_bank", rd_bank, 0);
        check("s1_rd_len", rd_len, 4);
        check("s1_wr_ready", wr_ready, 1);
        tick();
        check("s1_we_idle", ebr_we, 2'b00);

        // Short frame ends bank 0; next byte opens bank 1 at address 0
        do_reset();
        wr_byte(8'h11, 1'b0);
        wr_byte(8'h12, 1'b1);
        check("s2_rd_valid", rd_bank_valid, 1);
        check("s2_rd_len", rd_len, 2);
        wr_byte(8'h13, 1'b0);
        check("s2_we", ebr_we, 2'b10);
        check("s2_waddr", ebr_waddr, 0);
        check("s2_wdata", ebr_wdata, 8'h13);
        $display("short frame: rd_len=2 next we=%b addr=%0d", ebr_we, ebr_waddr);

        // Both banks full, ninth byte (with wr_last) is dropped
        do_reset();
        for (int i = 0; i < 8; i++) wr_byte(8'h20 + 8'(i), 1'b0);
        check("s3_wr_ready", wr_ready, 0);
        check("s3_rd_len0", rd_len, 4);
        wr_byte(8'h99, 1'b1);
        check("s3_drop_we", ebr_we, 2'b00);
        check("s3_overflow", overflow, 1);
        tick();
        tick();
        check("s3_overflow_sticky", overflow, 1);
        check("s3_wr_ready_hold", wr_ready, 0);
        check("s3_rd_bank", rd_bank, 0);
        $display("overflow: wr_ready=%0d overflow=%0d", wr_ready, overflow);

        // Release bank 0 while a byte is presented: that byte is still dropped
        rd_done  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        idle();
        check("s4_rd_bank", rd_bank, 1);
        check("s4_wr_ready", wr_ready, 1);
        check("s4_same_cycle_we", ebr_we, 2'b00);
        check("s4_rd_len1", rd_len, 4);
        wr_byte(8'h66, 1'b0);
        check("s4_we", ebr_we, 2'b01);
        check("s4_waddr", ebr_waddr, 0);
        check("s4_wdata", ebr_wdata, 8'h66);
        $display("release: rd_bank=%0d next we=%b addr=%0d", rd_bank, ebr_we, ebr_waddr);

        // Bank 1 completes in the same cycle bank 0 is released
        do_reset();
        for (int i = 0; i < 4; i++) wr_byte(8'h30 + 8'(i), 1'b0);
        wr_byte(8'h40, 1'b0);
        rd_done  = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        wr_last  = 1'b1;
        tick();
        idle();
        check("s5_we", ebr_we, 2'b10);
        check("s5_waddr", ebr_waddr, 1);
        check("s5_rd_bank", rd_bank, 1);
        check("s5_rd_valid", rd_bank_valid, 1);
        check("s5_rd_len", rd_len, 2);
        check("s5_wr_ready", wr_ready, 1);
        wr_byte(8'h42, 1'b0);
        check("s5_next_we", ebr_we, 2'b01);
        check("s5_next_waddr", ebr_waddr, 0);
        $display("simultaneous: rd_bank=%0d rd_len=%0d", rd_bank, rd_len);

        // Reset in mid-frame discards everything
        do_reset();
        wr_byte(8'h70, 1'b0);
        wr_byte(8'h71, 1'b0);
        do_reset();
        check("s6_wr_ready", wr_ready, 1);
        check("s6_rd_valid", rd_bank_valid, 0);
        check("s6_rd_len", rd_len, 0);
        check("s6_we", ebr_we, 0);
        check("s6_waddr", ebr_waddr, 0);
        check("s6_wdata", ebr_wdata, 0);
        check("s6_overflow", overflow, 0);
        wr_byte(8'h72, 1'b0);
        check("s6_next_we", ebr_we, 2'b01);
        check("s6_next_waddr", ebr_waddr, 0);
        wr_byte(8'h73, 1'b0);
        wr_byte(8'h74, 1'b0);
        check("s6_no_partial", rd_bank_valid, 0);
        wr_byte(8'h75, 1'b0);
        check("s6_full_after", rd_bank_valid, 1);
        check("s6_len_after", rd_len, 4);
        $display("mid-frame reset: next addr=0, bank refilled len=%0d", rd_len);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
